// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus master: bus addresses, FSM states,
// the registered bus-access word and the baud divisor table.
package spart_pkg;

    localparam logic [1:0] ADDR_BUF   = 2'b00;
    localparam logic [1:0] ADDR_STAT  = 2'b01;
    localparam logic [1:0] ADDR_DB_LO = 2'b10;
    localparam logic [1:0] ADDR_DB_HI = 2'b11;

    typedef enum logic [2:0] {
        CFG_LO,
        CFG_HI,
        IDLE,
        RD,
        RD_WAIT,
        WR,
        WR_WAIT
    } state_t;

    // One bus access as it appears on iocs/iorw/ioaddr/databus.
    typedef struct packed {
        logic       cs;
        logic       rw;
        logic [1:0] addr;
        logic [7:0] data;
    } access_t;

    localparam access_t ACC_IDLE = '{cs: 1'b0, rw: 1'b1, addr: ADDR_BUF, data: 8'h00};

    // Divisor for a 50 MHz clock at the selected baud rate.
    function automatic logic [15:0] baud_div(input logic [1:0] sel);
        case (sel)
            2'b00:   return 16'h028B;
            2'b01:   return 16'h0145;
            2'b10:   return 16'h00A2;
            default: return 16'h0051;
        endcase
    endfunction

endpackage

// File: rtl/spart_if.sv
// Control and status lines between the bus master and the SPART.
// The tri-state data bus is a separate inout port on the master.
interface spart_if;

    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, iorw, ioaddr, input rda, tbr);
    modport slave  (input iocs, iorw, ioaddr, output rda, tbr);

endinterface

// File: rtl/spart_driver_echo_fifo.sv
// Circular byte FIFO holding received bytes until they are echoed.
// Pointers carry one extra MSB so full and empty are distinguishable.
module echo_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor from the switches, then echoes
// every received byte back to the transmitter through a small FIFO.
module spart_driver
    import spart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    br_cfg,
    spart_if.master                       bus,
    inout  wire  [7:0]                    databus,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    state_t      state;
    state_t      state_nxt;
    access_t     acc;
    access_t     acc_q;
    logic [1:0]  cfg_meta;
    logic [1:0]  cfg_sync;
    logic [1:0]  cfg_prog;
    logic [15:0] div_new;
    logic [15:0] div_prog;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        rd_strobe;
    logic        wr_strobe;

    // Left unreset so the switch value is already settled when rst releases.
    always_ff @(posedge clk) begin
        cfg_meta <= br_cfg;
        cfg_sync <= cfg_meta;
    end

    assign div_new  = baud_div(cfg_sync);
    assign div_prog = baud_div(cfg_prog);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CFG_LO;
            acc_q    <= ACC_IDLE;
            cfg_prog <= 2'b01;
            overrun  <= 1'b0;
        end else begin
            state <= state_nxt;
            acc_q <= acc;
            if (state == CFG_LO)         cfg_prog <= cfg_sync;
            if (rd_strobe && fifo_full)  overrun  <= 1'b1;
        end
    end

    // The access chosen here is registered, so each strobe appears one cycle
    // after its state and the bus pins never depend on rda/tbr combinationally.
    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        acc       = '{cs: 1'b0, rw: 1'b1, addr: ADDR_BUF, data: acc_q.data};
        unique case (state)
            CFG_LO: begin
                acc       = '{cs: 1'b1, rw: 1'b0, addr: ADDR_DB_LO, data: div_new[7:0]};
                state_nxt = CFG_HI;
            end
            CFG_HI: begin
                acc       = '{cs: 1'b1, rw: 1'b0, addr: ADDR_DB_HI, data: div_prog[15:8]};
                state_nxt = IDLE;
            end
            IDLE: begin
                if (cfg_sync != cfg_prog)     state_nxt = CFG_LO;
                else if (bus.rda)             state_nxt = RD;
                else if (!fifo_empty && bus.tbr) state_nxt = WR;
            end
            RD: begin
                acc       = '{cs: 1'b1, rw: 1'b1, addr: ADDR_BUF, data: acc_q.data};
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (!bus.rda) state_nxt = IDLE;
            end
            WR: begin
                acc       = '{cs: 1'b1, rw: 1'b0, addr: ADDR_BUF, data: fifo_dout};
                state_nxt = WR_WAIT;
            end
            WR_WAIT: begin
                if (!bus.tbr) state_nxt = IDLE;
            end
            default: state_nxt = CFG_LO;
        endcase
    end

    assign bus.iocs   = acc_q.cs;
    assign bus.iorw   = acc_q.rw;
    assign bus.ioaddr = acc_q.addr;
    assign databus    = (acc_q.cs && !acc_q.rw) ? acc_q.data : 8'hzz;

    assign rd_strobe = acc_q.cs && acc_q.rw;
    assign wr_strobe = acc_q.cs && !acc_q.rw && (acc_q.addr == ADDR_BUF);

    // A read while full still completes on the bus; the FIFO ignores the push.
    echo_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_strobe),
        .pop   (wr_strobe),
        .din   (databus),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_spart_driver.sv
// Self-checking bench for spart_driver: SPART stand-in, queue-based echo model
// checked every cycle, directed scenarios and a randomized echo phase.
module tb_spart_driver;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] br_cfg;
    logic       overrun;
    logic [3:0] fifo_count;
    wire  [7:0] databus;
    logic [7:0] rx_byte;
    logic       tbr_hold;
    logic       tbr_busy;
    int         busy_cnt;
    logic       mon_en;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mq[$];
    logic       m_overrun;
    logic [7:0] echo_log[$];
    logic [9:0] cfg_log[$];
    int         ev_log[$];
    int         n_reads = 0;
    int         n_wr    = 0;
    int         n_acc   = 0;

    spart_if bus();

    assign bus.tbr = !tbr_hold && !tbr_busy;
    assign databus = (bus.iocs && bus.iorw) ? rx_byte : 8'hzz;

    spart_driver #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .br_cfg     (br_cfg),
        .bus        (bus),
        .databus    (databus),
        .overrun    (overrun),
        .fifo_count (fifo_count)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_div(input logic [1:0] s);
        case (s)
            2'b00:   exp_div = 16'h028B;
            2'b01:   exp_div = 16'h0145;
            2'b10:   exp_div = 16'h00A2;
            default: exp_div = 16'h0051;
        endcase
    endfunction

    // SPART transmitter: busy for a random few cycles after each accepted write.
    initial begin
        tbr_busy = 1'b0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (bus.iocs && !bus.iorw && bus.ioaddr == 2'b00) begin
                tbr_busy = 1'b1;
                busy_cnt = $urandom_range(1, 4);
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tbr_busy = 1'b0;
            end
        end
    end

    // Reference model: bytes read enter a bounded queue, writes must echo its head.
    always @(negedge clk) begin
        logic [15:0] d;
        if (!mon_en) begin
            mq.delete();
            m_overrun = 1'b0;
        end else begin
            check("fifo_count", 32'(fifo_count), 32'(mq.size()));
            check("overrun", 32'(overrun), 32'(m_overrun));
            d = exp_div(br_cfg);
            if (!bus.iocs) begin
                check("idle_bus", {29'd0, bus.iorw, bus.ioaddr}, 32'h4);
            end else if (bus.iorw) begin
                check("rd_addr", 32'(bus.ioaddr), 32'h0);
                n_reads++;
                ev_log.push_back(1);
                if (mq.size() < DEPTH) begin
                    mq.push_back(rx_byte);
                    n_acc++;
                end else begin
                    m_overrun = 1'b1;
                end
            end else begin
                case (bus.ioaddr)
                    2'b00: begin
                        ev_log.push_back(2);
                        n_wr++;
                        check("wr_nonempty", 32'(mq.size() != 0), 32'h1);
                        if (mq.size() != 0) begin
                            check("echo_data", 32'(databus), 32'(mq[0]));
                            echo_log.push_back(databus);
                            void'(mq.pop_front());
                        end
                    end
                    2'b10: begin
                        check("div_lo", 32'(databus), 32'(d[7:0]));
                        cfg_log.push_back({bus.ioaddr, databus});
                    end
                    2'b11: begin
                        check("div_hi", 32'(databus), 32'(d[15:8]));
                        cfg_log.push_back({bus.ioaddr, databus});
                    end
                    default: check("wr_addr", 32'(bus.ioaddr), 32'h0);
                endcase
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int hold, input logic rel_tbr);
        int n;
        @(negedge clk);
        rx_byte = b;
        bus.rda = 1'b1;
        if (rel_tbr) tbr_hold = 1'b0;
        n = 0;
        while (!(bus.iocs && bus.iorw) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rd_timeout", 32'(n < 100), 32'h1);
        repeat (hold) @(negedge clk);
        bus.rda = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((fifo_count != 0 || bus.iocs || !bus.tbr) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(n < 400), 32'h1);
    endtask

    task automatic expect_cfg_seq(input logic [7:0] lo, input logic [7:0] hi);
        @(negedge clk);
        check("cfg_lo_cs",   {30'd0, bus.iocs, bus.iorw}, 32'h2);
        check("cfg_lo_addr", 32'(bus.ioaddr), 32'h2);
        check("cfg_lo_data", 32'(databus), 32'(lo));
        @(negedge clk);
        check("cfg_hi_cs",   {30'd0, bus.iocs, bus.iorw}, 32'h2);
        check("cfg_hi_addr", 32'(bus.ioaddr), 32'h3);
        check("cfg_hi_data", 32'(databus), 32'(hi));
        @(negedge clk);
        check("cfg_done_idle", 32'(bus.iocs), 32'h0);
    endtask

    initial begin
        int base;
        int c0;
        int r0;
        int w0;
        int a0;
        int n;
        logic [7:0] b;

        rst      = 1'b1;
        br_cfg   = 2'b10;
        mon_en   = 1'b0;
        rx_byte  = 8'h00;
        bus.rda  = 1'b0;
        tbr_hold = 1'b0;

        // Reset state and the initial divisor programming.
        repeat (5) @(negedge clk);
        check("rst_iocs", 32'(bus.iocs), 32'h0);
        check("rst_iorw", 32'(bus.iorw), 32'h1);
        check("rst_addr", 32'(bus.ioaddr), 32'h0);
        check("rst_ovr",  32'(overrun), 32'h0);
        check("rst_cnt",  32'(fifo_count), 32'h0);
        rst    = 1'b0;
        mon_en = 1'b1;
        expect_cfg_seq(8'hA2, 8'h00);
        repeat (3) @(negedge clk);

        // Single echo.
        base = echo_log.size();
        send_byte(8'h41, 0, 1'b0);
        @(negedge clk);
        check("echo_cnt_one", 32'(fifo_count), 32'h1);
        wait_drain();
        check("echo_count", 32'(echo_log.size() - base), 32'h1);
        if (echo_log.size() > base) check("echo_41", 32'(echo_log[base]), 32'h41);

        // Fill past capacity with the transmitter stalled.
        tbr_hold = 1'b1;
        for (int i = 0; i < 9; i++) begin
            b = 8'h10 + 8'(i);
            send_byte(b, 0, 1'b0);
        end
        repeat (2) @(negedge clk);
        check("full_cnt", 32'(fifo_count), 32'h8);
        check("full_ovr", 32'(overrun), 32'h1);
        base = echo_log.size();
        tbr_hold = 1'b0;
        wait_drain();
        check("ovf_echo_count", 32'(echo_log.size() - base), 32'h8);
        for (int i = 0; i < 8; i++) begin
            if (echo_log.size() > base + i)
                check("ovf_echo_order", 32'(echo_log[base + i]), 32'h10 + 32'(i));
        end

        // rda and tbr rise together with one byte queued; rda held long.
        tbr_hold = 1'b1;
        send_byte(8'h55, 0, 1'b0);
        repeat (3) @(negedge clk);
        c0   = ev_log.size();
        r0   = n_reads;
        base = echo_log.size();
        send_byte(8'h66, 4, 1'b1);
        wait_drain();
        if (ev_log.size() > c0) check("read_first", 32'(ev_log[c0]), 32'h1);
        check("single_read", 32'(n_reads - r0), 32'h1);
        check("both_echo_count", 32'(echo_log.size() - base), 32'h2);
        if (echo_log.size() > base + 1) begin
            check("both_echo0", 32'(echo_log[base]), 32'h55);
            check("both_echo1", 32'(echo_log[base + 1]), 32'h66);
        end

        // Baud change while idle with a byte held in the FIFO.
        tbr_hold = 1'b1;
        send_byte(8'h3C, 0, 1'b0);
        repeat (3) @(negedge clk);
        c0 = cfg_log.size();
        br_cfg = 2'b01;
        repeat (12) @(negedge clk);
        check("cfg01_writes", 32'(cfg_log.size() - c0), 32'h2);
        if (cfg_log.size() > c0 + 1) begin
            check("cfg01_lo", 32'(cfg_log[c0]), 32'h245);
            check("cfg01_hi", 32'(cfg_log[c0 + 1]), 32'h301);
        end
        c0 = cfg_log.size();
        br_cfg = 2'b11;
        repeat (12) @(negedge clk);
        check("cfg11_writes", 32'(cfg_log.size() - c0), 32'h2);
        if (cfg_log.size() > c0 + 1) begin
            check("cfg11_lo", 32'(cfg_log[c0]), 32'h251);
            check("cfg11_hi", 32'(cfg_log[c0 + 1]), 32'h300);
        end
        check("cfg_fifo_kept", 32'(fifo_count), 32'h1);
        base = echo_log.size();
        tbr_hold = 1'b0;
        wait_drain();
        if (echo_log.size() > base) check("cfg_echo_3c", 32'(echo_log[base]), 32'h3C);
        else check("cfg_echo_count", 32'(echo_log.size() - base), 32'h1);

        // Reset asserted during a write strobe.
        tbr_hold = 1'b1;
        send_byte(8'h77, 0, 1'b0);
        send_byte(8'h78, 0, 1'b0);
        @(negedge clk);
        tbr_hold = 1'b0;
        n = 0;
        while (!(bus.iocs && !bus.iorw && bus.ioaddr == 2'b00) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wr_strobe_timeout", 32'(n < 50), 32'h1);
        rst    = 1'b1;
        mon_en = 1'b0;
        #1;
        check("rstwr_iocs", 32'(bus.iocs), 32'h0);
        check("rstwr_iorw", 32'(bus.iorw), 32'h1);
        check("rstwr_cnt",  32'(fifo_count), 32'h0);
        check("rstwr_ovr",  32'(overrun), 32'h0);
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        expect_cfg_seq(8'h51, 8'h00);
        check("rstwr_cnt_after", 32'(fifo_count), 32'h0);
        repeat (6) @(negedge clk);

        // Randomized traffic with random transmitter stalls.
        w0 = n_wr;
        a0 = n_acc;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 7) == 0) tbr_hold = ~tbr_hold;
            send_byte(8'($urandom), $urandom_range(0, 3), 1'b0);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        tbr_hold = 1'b0;
        wait_drain();
        check("rand_echo_total", 32'(n_wr - w0), 32'(n_acc - a0));

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
